// File: rtl/kronos_timer_pkg.sv
// kronos_timer_pkg: register offsets, FSM states and the byte-merge helper
// shared by the Kronos machine-timer front end.
package kronos_timer_pkg;
    localparam logic [1:0] MTIME_LO = 2'd0;
    localparam logic [1:0] MTIME_HI = 2'd1;
    localparam logic [1:0] CMP_LO   = 2'd2;
    localparam logic [1:0] CMP_HI   = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_e;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                               input logic [31:0] wdat,
                                               input logic [3:0]  sel);
        for (int i = 0; i < 4; i++)
            byte_merge[i*8 +: 8] = sel[i] ? wdat[i*8 +: 8] : old_w[i*8 +: 8];
    endfunction
endpackage

// File: rtl/kronos_prescaler.sv
// kronos_prescaler: free-running divider; tick is high for one cycle in every
// PRESCALE, and stays low while in reset.
module kronos_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rstz,
    output logic tick
);
    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    // tick is registered so it tracks cnt_q == LAST yet still reads 0 in reset
    always_comb begin
        cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        tick_d = (cnt_d == LAST);
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;
endmodule

// File: rtl/kronos_timer_cmp.sv
// kronos_timer_cmp: Wishbone machine-timer front end with atomic mtime reads,
// mtimecmp register and level timer interrupt.
module kronos_timer_cmp
    import kronos_timer_pkg::*;
#(
    parameter int          PRESCALE  = 1,
    parameter logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clk,
    input  logic        rstz,
    input  logic [3:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_stb_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    input  logic [63:0] count_i,
    input  logic        count_vld_i,
    output logic        incr_o,
    output logic [31:0] load_data_o,
    output logic        load_low_o,
    output logic        load_high_o,
    output logic        timer_irq_o
);
    state_e      state_q, state_d;
    logic [31:0] snap_hi_q, snap_hi_d;
    logic [31:0] dat_q, dat_d;
    logic [63:0] cmp_q, cmp_d;
    logic [31:0] load_data_q, load_data_d;
    logic        load_low_q, load_low_d;
    logic        load_high_q, load_high_d;
    logic        irq_q, irq_d;
    logic [1:0]  reg_sel;
    logic        rd_lo_stall, enter_ack;
    logic        unused_adr;

    assign unused_adr = ^wb_adr_i[1:0];

    kronos_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk  (clk),
        .rstz (rstz),
        .tick (incr_o)
    );

    always_comb begin
        reg_sel     = wb_adr_i[3:2];
        // a low-word read must not sample the counter while its upper word is in flux
        rd_lo_stall = !wb_we_i && reg_sel == MTIME_LO && !count_vld_i;
        enter_ack   = (state_q == IDLE && wb_stb_i && !rd_lo_stall) ||
                      (state_q == WAIT && count_vld_i);
        state_d     = (state_q == ACK) ? IDLE :
                      enter_ack ? ACK :
                      (state_q == IDLE && wb_stb_i) ? WAIT : state_q;
        snap_hi_d   = snap_hi_q;
        dat_d       = dat_q;
        cmp_d       = cmp_q;
        load_data_d = load_data_q;
        load_low_d  = 1'b0;
        load_high_d = 1'b0;
        if (enter_ack && wb_we_i) begin
            dat_d        = '0;
            load_low_d   = reg_sel == MTIME_LO;
            load_high_d  = reg_sel == MTIME_HI;
            load_data_d  = (reg_sel == MTIME_LO || reg_sel == MTIME_HI) ? wb_dat_i : load_data_q;
            cmp_d[31:0]  = (reg_sel == CMP_LO) ? byte_merge(cmp_q[31:0], wb_dat_i, wb_sel_i) : cmp_q[31:0];
            cmp_d[63:32] = (reg_sel == CMP_HI) ? byte_merge(cmp_q[63:32], wb_dat_i, wb_sel_i) : cmp_q[63:32];
        end else if (enter_ack) begin
            dat_d     = (reg_sel == MTIME_LO) ? count_i[31:0] :
                        (reg_sel == MTIME_HI) ? snap_hi_q :
                        (reg_sel == CMP_LO)   ? cmp_q[31:0] : cmp_q[63:32];
            snap_hi_d = (reg_sel == MTIME_LO) ? count_i[63:32] : snap_hi_q;
        end
        irq_d = count_vld_i ? (count_i >= cmp_q) : irq_q;
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state_q     <= IDLE;
            snap_hi_q   <= '0;
            dat_q       <= '0;
            cmp_q       <= CMP_RESET;
            load_data_q <= '0;
            load_low_q  <= 1'b0;
            load_high_q <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            snap_hi_q   <= snap_hi_d;
            dat_q       <= dat_d;
            cmp_q       <= cmp_d;
            load_data_q <= load_data_d;
            load_low_q  <= load_low_d;
            load_high_q <= load_high_d;
            irq_q       <= irq_d;
        end
    end

    assign wb_ack_o    = (state_q == ACK);
    assign wb_dat_o    = dat_q;
    assign load_data_o = load_data_q;
    assign load_low_o  = load_low_q;
    assign load_high_o = load_high_q;
    assign timer_irq_o = irq_q;
endmodule

// File: tb/tb_kronos_timer_cmp.sv
// tb_kronos_timer_cmp: directed bench for kronos_timer_cmp with PRESCALE=4;
// read data is checked through an expected-value scoreboard.
module tb_kronos_timer_cmp;
    logic        clk;
    logic        rstz;
    logic [3:0]  wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_stb_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic [63:0] count_i;
    logic        count_vld_i;
    logic        incr_o;
    logic [31:0] load_data_o;
    logic        load_low_o;
    logic        load_high_o;
    logic        timer_irq_o;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] sb_q[$];
    string       tag_q[$];

    kronos_timer_cmp #(.PRESCALE(4)) dut (
        .clk         (clk),
        .rstz        (rstz),
        .wb_adr_i    (wb_adr_i),
        .wb_dat_i    (wb_dat_i),
        .wb_sel_i    (wb_sel_i),
        .wb_we_i     (wb_we_i),
        .wb_stb_i    (wb_stb_i),
        .wb_dat_o    (wb_dat_o),
        .wb_ack_o    (wb_ack_o),
        .count_i     (count_i),
        .count_vld_i (count_vld_i),
        .incr_o      (incr_o),
        .load_data_o (load_data_o),
        .load_low_o  (load_low_o),
        .load_high_o (load_high_o),
        .timer_irq_o (timer_irq_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // drives one request, scores the read data at ack and leaves time at the ack negedge
    task automatic wb(input logic we, input logic [3:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, input logic [31:0] exp, input string tag,
                      output int lat);
        @(negedge clk);
        wb_we_i  = we;
        wb_adr_i = adr;
        wb_dat_i = dat;
        wb_sel_i = sel;
        wb_stb_i = 1'b1;
        sb_q.push_back(exp);
        tag_q.push_back(tag);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!wb_ack_o && lat < 10);
        chk({tag, "_ack"}, 64'(wb_ack_o), 64'd1);
        chk(tag_q.pop_front(), 64'(wb_dat_o), 64'(sb_q.pop_front()));
        wb_stb_i = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ack"}, 64'(wb_ack_o), 64'd0);
        chk({tag, "_dat"}, 64'(wb_dat_o), 64'd0);
        chk({tag, "_incr"}, 64'(incr_o), 64'd0);
        chk({tag, "_ldat"}, 64'(load_data_o), 64'd0);
        chk({tag, "_llo"}, 64'(load_low_o), 64'd0);
        chk({tag, "_lhi"}, 64'(load_high_o), 64'd0);
        chk({tag, "_irq"}, 64'(timer_irq_o), 64'd0);
    endtask

    initial begin
        int lat;
        rstz        = 1'b0;
        wb_adr_i    = '0;
        wb_dat_i    = '0;
        wb_sel_i    = '0;
        wb_we_i     = 1'b0;
        wb_stb_i    = 1'b0;
        count_i     = 64'h0;
        count_vld_i = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_outputs("rst");

        // prescaler: first post-reset cycle is cycle 1, incr on every 4th
        rstz = 1'b1;
        chk("incr_c1", 64'(incr_o), 64'd0);
        for (int k = 2; k <= 12; k++) begin
            @(negedge clk);
            chk($sformatf("incr_c%0d", k), 64'(incr_o), 64'((k % 4) == 0));
        end
        chk("irq_after_rst", 64'(timer_irq_o), 64'd0);

        wb(1'b0, 4'h8, 32'h0, 4'hF, 32'hFFFF_FFFF, "rd_cmp_lo_rst", lat);
        chk("lat_cmp_lo", 64'(lat), 64'd1);
        wb(1'b0, 4'hC, 32'h0, 4'hF, 32'hFFFF_FFFF, "rd_cmp_hi_rst", lat);

        // compare threshold at 0x10
        count_i = 64'h0F;
        wb(1'b1, 4'h8, 32'h10, 4'hF, 32'h0, "wr_cmp_lo", lat);
        wb(1'b1, 4'hC, 32'h0, 4'hF, 32'h0, "wr_cmp_hi", lat);
        @(negedge clk);
        chk("irq_below", 64'(timer_irq_o), 64'd0);
        count_i = 64'h10;
        @(negedge clk);
        chk("irq_equal", 64'(timer_irq_o), 64'd1);

        // all-ones count, then hold with vld low, then wrap to 0
        count_i = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        chk("irq_max", 64'(timer_irq_o), 64'd1);
        count_i     = 64'h0;
        count_vld_i = 1'b0;
        @(negedge clk);
        chk("irq_hold", 64'(timer_irq_o), 64'd1);
        count_vld_i = 1'b1;
        @(negedge clk);
        chk("irq_wrap", 64'(timer_irq_o), 64'd0);

        // lo read stalled one cycle by vld=0 across a carry into the upper word
        @(negedge clk);
        count_i     = 64'h1_FFFF_FFFF;
        count_vld_i = 1'b0;
        wb_we_i     = 1'b0;
        wb_adr_i    = 4'h0;
        wb_stb_i    = 1'b1;
        sb_q.push_back(32'h0);
        tag_q.push_back("rd_lo_wait");
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                count_i     = 64'h2_0000_0000;
                count_vld_i = 1'b1;
            end
        end while (!wb_ack_o && lat < 10);
        chk("lat_lo_wait", 64'(lat), 64'd2);
        chk(tag_q.pop_front(), 64'(wb_dat_o), 64'(sb_q.pop_front()));
        wb_stb_i = 1'b0;
        count_i  = 64'h5_0000_0000;
        wb(1'b0, 4'h4, 32'h0, 4'hF, 32'h2, "rd_hi_snap", lat);

        wb(1'b0, 4'h0, 32'h0, 4'hF, 32'h0, "rd_lo_direct", lat);
        count_i = 64'h7_1234_5678;
        wb(1'b0, 4'h0, 32'h0, 4'hF, 32'h1234_5678, "rd_lo_vld", lat);
        chk("lat_lo_vld", 64'(lat), 64'd1);
        wb(1'b0, 4'h4, 32'h0, 4'hF, 32'h7, "rd_hi_vld", lat);

        // mtime_hi write drives a single load_high pulse
        wb(1'b1, 4'h4, 32'hABCD, 4'h1, 32'h0, "wr_mtime_hi", lat);
        chk("lhi_pulse", 64'(load_high_o), 64'd1);
        chk("llo_quiet", 64'(load_low_o), 64'd0);
        chk("ldat_hi", 64'(load_data_o), 64'hABCD);
        @(negedge clk);
        chk("lhi_after", 64'(load_high_o), 64'd0);

        // byte-enable merge into cmp_lo
        wb(1'b1, 4'h8, 32'hFFFF_FFFF, 4'hF, 32'h0, "wr_cmp_ones", lat);
        wb(1'b1, 4'h8, 32'h0000_5500, 4'b0010, 32'h0, "wr_cmp_sel", lat);
        wb(1'b0, 4'h8, 32'h0, 4'hF, 32'hFFFF_55FF, "rd_cmp_merge", lat);
        @(negedge clk);
        chk("irq_pre_rst", 64'(timer_irq_o), 64'd1);

        // reset while the FSM is parked in WAIT
        wb_we_i     = 1'b0;
        wb_adr_i    = 4'h0;
        wb_stb_i    = 1'b1;
        count_vld_i = 1'b0;
        @(negedge clk);
        chk("wait_no_ack", 64'(wb_ack_o), 64'd0);
        rstz = 1'b0;
        #1;
        chk_reset_outputs("rst_wait");
        wb_stb_i    = 1'b0;
        count_vld_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("rst_ack_%0d", k), 64'(wb_ack_o), 64'd0);
        end
        rstz = 1'b1;
        @(negedge clk);
        chk("post_rst_ack", 64'(wb_ack_o), 64'd0);
        wb(1'b0, 4'h8, 32'h0, 4'hF, 32'hFFFF_FFFF, "rd_cmp_lo_rst2", lat);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
